// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified I/D SRAM port arbiter: FSM states, grant
// codes and the latched SRAM request.
package mem_port_arbiter_pkg;

  localparam logic [1:0] MA_IDLE  = 2'b00;
  localparam logic [1:0] MA_ISSUE = 2'b01;
  localparam logic [1:0] MA_WAIT  = 2'b10;
  localparam logic [1:0] MA_DONE  = 2'b11;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // MEM-stage access is older than the fetch behind it, so it always wins.
  function automatic logic [1:0] pick_grant(input logic data_req, input logic inst_req);
    if (data_req)      return GNT_D;
    else if (inst_req) return GNT_I;
    else               return GNT_NONE;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM sequencer shared by IF and MEM: data-priority arbitration,
// fixed-latency reads, one-cycle ready pulses and per-stage stall outputs.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_rdata_o,
  output logic        inst_ready_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_ready_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_if_o,
  output logic        stall_mem_o
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_req_t         req_q, req_d;
  logic             mem_en_q, mem_en_d;
  logic [31:0]      inst_rdata_q, inst_rdata_d;
  logic [31:0]      data_rdata_q, data_rdata_d;
  logic             inst_ready_q, inst_ready_d;
  logic             data_ready_q, data_ready_d;
  logic [1:0]       win;

  assign win = pick_grant(data_req_i, inst_req_i);

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    mem_en_d     = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_ready_d = 1'b0;
    data_ready_d = 1'b0;
    case (state_q)
      MA_IDLE: begin
        if (win != GNT_NONE) begin
          gnt_d    = win;
          mem_en_d = 1'b1;
          state_d  = MA_ISSUE;
          if (win == GNT_D) req_d = '{we: data_we_i, addr: data_addr_i, wdata: data_wdata_i};
          else              req_d = '{we: 1'b0, addr: inst_addr_i, wdata: '0};
        end
      end
      MA_ISSUE: begin
        // Stores complete without a read-back; only loads/fetches wait.
        if (req_q.we) begin
          data_ready_d = 1'b1;
          state_d      = MA_DONE;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = MA_WAIT;
        end
      end
      MA_WAIT: begin
        if (cnt_q == '0) begin
          state_d = MA_DONE;
          if (gnt_q == GNT_D) begin
            data_rdata_d = mem_rdata_i;
            data_ready_d = 1'b1;
          end else begin
            inst_rdata_d = mem_rdata_i;
            inst_ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        gnt_d   = GNT_NONE;
        state_d = MA_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= MA_IDLE;
      gnt_q        <= GNT_NONE;
      cnt_q        <= '0;
      req_q        <= '0;
      mem_en_q     <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      mem_en_q     <= mem_en_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_ready_q <= inst_ready_d;
      data_ready_q <= data_ready_d;
    end
  end

  assign mem_en_o     = mem_en_q;
  assign mem_we_o     = mem_en_q & req_q.we;
  assign mem_addr_o   = req_q.addr;
  assign mem_wdata_o  = req_q.wdata;
  assign inst_rdata_o = inst_rdata_q;
  assign data_rdata_o = data_rdata_q;
  assign inst_ready_o = inst_ready_q;
  assign data_ready_o = data_ready_q;
  assign stall_if_o   = inst_req_i & ~inst_ready_q;
  assign stall_mem_o  = data_req_i & ~data_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cycle table, multi-cycle corner sequences,
// latency sweep instances and a randomized run against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam logic [31:0] J = 32'hBAD0_0BAD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ireq, dreq, dwe;
  logic [31:0] iaddr, daddr, dwd, mrd;
  logic [31:0] irdata, drdata, maddr, mwd;
  logic        irdy, drdy, men, mwe, sif, smem;

  logic        s1_req, s15_req, zero;
  logic [31:0] s_addr, s_mrd, zero32;
  logic [31:0] l1_irdata, l1_drdata, l1_maddr, l1_mwd;
  logic        l1_irdy, l1_drdy, l1_men, l1_mwe, l1_sif, l1_smem;
  logic [31:0] l15_irdata, l15_drdata, l15_maddr, l15_mwd;
  logic        l15_irdy, l15_drdy, l15_men, l15_mwe, l15_sif, l15_smem;

  mem_port_arbiter #(.MEM_LATENCY(LAT), .CNT_W(4)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .inst_req_i(ireq), .inst_addr_i(iaddr), .inst_rdata_o(irdata), .inst_ready_o(irdy),
    .data_req_i(dreq), .data_we_i(dwe), .data_addr_i(daddr), .data_wdata_i(dwd),
    .data_rdata_o(drdata), .data_ready_o(drdy),
    .mem_en_o(men), .mem_we_o(mwe), .mem_addr_o(maddr), .mem_wdata_o(mwd), .mem_rdata_i(mrd),
    .stall_if_o(sif), .stall_mem_o(smem));

  mem_port_arbiter #(.MEM_LATENCY(1), .CNT_W(4)) u_lat1 (
    .clk_i(clk), .rst_i(rst),
    .inst_req_i(s1_req), .inst_addr_i(s_addr), .inst_rdata_o(l1_irdata), .inst_ready_o(l1_irdy),
    .data_req_i(zero), .data_we_i(zero), .data_addr_i(zero32), .data_wdata_i(zero32),
    .data_rdata_o(l1_drdata), .data_ready_o(l1_drdy),
    .mem_en_o(l1_men), .mem_we_o(l1_mwe), .mem_addr_o(l1_maddr), .mem_wdata_o(l1_mwd),
    .mem_rdata_i(s_mrd), .stall_if_o(l1_sif), .stall_mem_o(l1_smem));

  mem_port_arbiter #(.MEM_LATENCY(15), .CNT_W(4)) u_lat15 (
    .clk_i(clk), .rst_i(rst),
    .inst_req_i(s15_req), .inst_addr_i(s_addr), .inst_rdata_o(l15_irdata), .inst_ready_o(l15_irdy),
    .data_req_i(zero), .data_we_i(zero), .data_addr_i(zero32), .data_wdata_i(zero32),
    .data_rdata_o(l15_drdata), .data_ready_o(l15_drdy),
    .mem_en_o(l15_men), .mem_we_o(l15_mwe), .mem_addr_o(l15_maddr), .mem_wdata_o(l15_mwd),
    .mem_rdata_i(s_mrd), .stall_if_o(l15_sif), .stall_mem_o(l15_smem));

  typedef struct packed {
    logic        ireq;  logic [31:0] iaddr;
    logic        dreq;  logic dwe; logic [31:0] daddr; logic [31:0] dwd;
    logic [31:0] mrd;
    logic        en;    logic we;  logic [31:0] maddr; logic [31:0] mwd;
    logic        irdy;  logic drdy; logic [31:0] irdata; logic [31:0] drdata;
    logic        sif;   logic smem;
  } vec_t;

  vec_t tbl[19];
  int   nvec = 0, nerr = 0;

  // randomized-phase model state
  bit          pend, pport_d, pwe, done_i, done_d, e_en, e_irdy, e_drdy;
  int          iss_c, rdy_c, next_idle, rd_due, r1, r15;
  logic [31:0] paddr, pwd, pexp, rd_val;
  logic [31:0] sram[16], gold[16];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic dload(input logic [31:0] a, input logic [31:0] w, input string nm);
    for (int k = 0; k <= 2 + LAT; k++) begin
      step();
      if (k == 0) begin dreq = 1'b1; dwe = 1'b0; daddr = a; end
      mrd = (k == 1 + LAT) ? w : J;
      #1;
      chk({nm, ".mem_en"}, 32'(men), 32'(k == 1));
      if (k == 1) chk({nm, ".mem_addr"}, maddr, a);
      chk({nm, ".ready"}, 32'(drdy), 32'(k == 2 + LAT));
    end
    chk({nm, ".rdata"}, drdata, w);
  endtask

  initial begin
    rst = 1'b1; ireq = 0; dreq = 0; dwe = 0; iaddr = 0; daddr = 0; dwd = 0; mrd = J;
    s1_req = 0; s15_req = 0; zero = 0; zero32 = 0; s_addr = 0; s_mrd = 0;

    tbl[0]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, J,           1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
    tbl[1]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, J,           1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
    tbl[2]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, J,           1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
    tbl[3]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 32'h3C011234,1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
    tbl[4]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, J,           1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h3C011234, 32'h0,        1'b0, 1'b0};
    tbl[5]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h100, 32'hDEADBEEF, J,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h3C011234, 32'h0,        1'b0, 1'b1};
    tbl[6]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h100, 32'hDEADBEEF, J,  1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 32'h3C011234, 32'h0,        1'b0, 1'b1};
    tbl[7]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h100, 32'hDEADBEEF, J,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h3C011234, 32'h0,        1'b0, 1'b0};
    tbl[8]  = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h40, 32'h0, J,          1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h3C011234, 32'h0,        1'b1, 1'b1};
    tbl[9]  = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h40, 32'h0, J,          1'b1, 1'b0, 32'h40,  32'h0,        1'b0, 1'b0, 32'h3C011234, 32'h0,        1'b1, 1'b1};
    tbl[10] = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h40, 32'h0, J,          1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h3C011234, 32'h0,        1'b1, 1'b1};
    tbl[11] = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h40, 32'h0, 32'hA5A50040,1'b0,1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h3C011234, 32'h0,        1'b1, 1'b1};
    tbl[12] = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h40, 32'h0, J,          1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h3C011234, 32'hA5A50040, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, J,           1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h3C011234, 32'hA5A50040, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, J,           1'b1, 1'b0, 32'h20,  32'h0,        1'b0, 1'b0, 32'h3C011234, 32'hA5A50040, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, J,           1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h3C011234, 32'hA5A50040, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 32'h11110020,1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h3C011234, 32'hA5A50040, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, J,           1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h11110020, 32'hA5A50040, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0, J,           1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h11110020, 32'hA5A50040, 1'b0, 1'b0};

    repeat (3) step();
    chk("rst.mem_en", 32'(men), 0);      chk("rst.mem_we", 32'(mwe), 0);
    chk("rst.mem_addr", maddr, 0);       chk("rst.mem_wdata", mwd, 0);
    chk("rst.inst_rdata", irdata, 0);    chk("rst.data_rdata", drdata, 0);
    chk("rst.inst_ready", 32'(irdy), 0); chk("rst.data_ready", 32'(drdy), 0);
    rst = 1'b0;

    // directed table: single fetch, store, contention
    for (int r = 0; r < 19; r++) begin
      step();
      ireq = tbl[r].ireq; iaddr = tbl[r].iaddr; dreq = tbl[r].dreq; dwe = tbl[r].dwe;
      daddr = tbl[r].daddr; dwd = tbl[r].dwd; mrd = tbl[r].mrd;
      #1;
      chk($sformatf("tbl%0d.mem_en", r), 32'(men), 32'(tbl[r].en));
      if (tbl[r].en) begin
        chk($sformatf("tbl%0d.mem_addr", r), maddr, tbl[r].maddr);
        chk($sformatf("tbl%0d.mem_we", r), 32'(mwe), 32'(tbl[r].we));
        if (tbl[r].we) chk($sformatf("tbl%0d.mem_wdata", r), mwd, tbl[r].mwd);
      end
      chk($sformatf("tbl%0d.inst_ready", r), 32'(irdy), 32'(tbl[r].irdy));
      chk($sformatf("tbl%0d.data_ready", r), 32'(drdy), 32'(tbl[r].drdy));
      chk($sformatf("tbl%0d.inst_rdata", r), irdata, tbl[r].irdata);
      chk($sformatf("tbl%0d.data_rdata", r), drdata, tbl[r].drdata);
      chk($sformatf("tbl%0d.stall_if", r), 32'(sif), 32'(tbl[r].sif));
      chk($sformatf("tbl%0d.stall_mem", r), 32'(smem), 32'(tbl[r].smem));
    end

    // back-to-back loads: second request in the cycle after the first ready
    dload(32'h80, 32'hCAFE0080, "b2b0");
    dload(32'h84, 32'hCAFE0084, "b2b1");

    // reset in the middle of a fetch's wait
    step(); dreq = 1'b0; ireq = 1'b1; iaddr = 32'h30; mrd = J;
    step();
    step(); rst = 1'b1;
    step(); rst = 1'b0; ireq = 1'b0; mrd = 32'h77777777;
    #1;
    chk("rstw.mem_en", 32'(men), 0);      chk("rstw.inst_ready", 32'(irdy), 0);
    chk("rstw.inst_rdata", irdata, 0);    chk("rstw.data_rdata", drdata, 0);
    chk("rstw.mem_addr", maddr, 0);       chk("rstw.mem_we", 32'(mwe), 0);
    chk("rstw.stall_if", 32'(sif), 0);
    for (int k = 0; k < 4; k++) begin
      step(); mrd = J; #1;
      chk("rstw.no_ready", 32'(irdy), 0);
      chk("rstw.no_en", 32'(men), 0);
    end

    // latency extremes: fetch at T, ready expected at T+3 and T+17
    step(); s1_req = 1'b1; s15_req = 1'b1; s_addr = 32'h44; s_mrd = 32'h5EE90044;
    r1 = -1; r15 = -1;
    for (int c = 0; c < 25; c++) begin
      if (c > 0) step();
      #1;
      if (l1_irdy && r1 < 0) r1 = c;
      if (l15_irdy && r15 < 0) r15 = c;
      if (l1_irdy) s1_req = 1'b0;
      if (l15_irdy) s15_req = 1'b0;
    end
    chk("lat1.ready_cycle", 32'(r1), 3);
    chk("lat15.ready_cycle", 32'(r15), 17);
    chk("lat1.rdata", l1_irdata, 32'h5EE90044);
    chk("lat15.rdata", l15_irdata, 32'h5EE90044);

    // randomized traffic against a transaction-level model
    for (int i = 0; i < 16; i++) begin sram[i] = $urandom; gold[i] = sram[i]; end
    pend = 0; done_i = 0; done_d = 0; next_idle = 0; rd_due = -1;
    for (int c = 0; c < 800; c++) begin
      step();
      e_en   = pend && c == iss_c;
      e_irdy = pend && !pport_d && c == rdy_c;
      e_drdy = pend && pport_d && c == rdy_c;
      if (done_i || !ireq) begin
        ireq = ($urandom_range(0, 2) == 0); iaddr = 32'($urandom_range(0, 15)) << 2; done_i = 0;
      end
      if (done_d || !dreq) begin
        dreq = ($urandom_range(0, 2) == 0); dwe = 1'($urandom_range(0, 1));
        daddr = 32'($urandom_range(0, 15)) << 2; dwd = $urandom; done_d = 0;
      end
      mrd = (c == rd_due) ? rd_val : $urandom;
      #1;
      chk("rnd.mem_en", 32'(men), 32'(e_en));
      if (e_en) begin
        chk("rnd.mem_addr", maddr, paddr);
        chk("rnd.mem_we", 32'(mwe), 32'(pwe));
        if (pwe) chk("rnd.mem_wdata", mwd, pwd);
      end
      chk("rnd.inst_ready", 32'(irdy), 32'(e_irdy));
      chk("rnd.data_ready", 32'(drdy), 32'(e_drdy));
      if (e_irdy) chk("rnd.inst_rdata", irdata, pexp);
      if (e_drdy && !pwe) chk("rnd.data_rdata", drdata, pexp);
      chk("rnd.stall_if", 32'(sif), 32'(ireq & ~e_irdy));
      chk("rnd.stall_mem", 32'(smem), 32'(dreq & ~e_drdy));
      if (men) begin
        if (mwe) sram[maddr[5:2]] = mwd;
        else begin rd_due = c + LAT; rd_val = sram[maddr[5:2]]; end
      end
      if (e_irdy) done_i = 1;
      if (e_drdy) done_d = 1;
      if (pend && c == rdy_c) pend = 0;
      if (!pend && c >= next_idle && (dreq || ireq)) begin
        pend = 1; pport_d = dreq;
        pwe   = dreq ? dwe : 1'b0;
        paddr = dreq ? daddr : iaddr;
        pwd   = dwd;
        iss_c = c + 1;
        rdy_c = c + (pwe ? 2 : 2 + LAT);
        next_idle = rdy_c + 1;
        if (pwe) gold[paddr[5:2]] = pwd;
        else     pexp = gold[paddr[5:2]];
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences a single-port unified instruction/data SRAM shared between the IF stage (instruction fetch) and the MEM stage (lw/sw, qualified by the decoder's memen/memwrite).
- Arbitrates the two requesters and drives the SRAM through a fixed-latency read protocol.
- Returns read data with a one-cycle ready pulse and produces per-stage stall signals for the hazard logic.

Parameters:
- MEM_LATENCY, 2, cycles from the SRAM enable cycle to the cycle mem_rdata is valid (legal range 1..15).
- CNT_W, 4, width of the latency counter; must hold MEM_LATENCY.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_req  in  1  IF fetch request; held high until inst_ready.
- inst_addr  in  32  fetch byte address (word aligned).
- inst_rdata  out  32  fetched word; valid while inst_ready=1.
- inst_ready  out  1  one-cycle completion pulse for the fetch.
- data_req  in  1  MEM-stage access request (memen); held until data_ready.
- data_we  in  1  1 = store (memwrite), 0 = load.
- data_addr  in  32  load/store byte address (word aligned).
- data_wdata  in  32  store data.
- data_rdata  out  32  loaded word; valid while data_ready=1.
- data_ready  out  1  one-cycle completion pulse for the load or store.
- mem_en  out  1  SRAM access enable; high for exactly one cycle per access.
- mem_we  out  1  SRAM write enable; only meaningful with mem_en.
- mem_addr  out  32  SRAM byte address.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data; valid MEM_LATENCY cycles after the mem_en cycle.
- stall_if  out  1  combinational: inst_req & ~inst_ready.
- stall_mem  out  1  combinational: data_req & ~data_ready.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE.
- Reset values: state=IDLE, counter=0, grant=none, and every registered output 0 (mem_en, mem_we, mem_addr, mem_wdata, inst_rdata, data_rdata, inst_ready, data_ready).
- IDLE, cycle T:
  - If data_req=1, grant D. Else if inst_req=1, grant I. Else stay in IDLE.
  - Fixed priority to data: the MEM-stage instruction is older, and the IF stage is stalled behind it, so there is no starvation.
  - On a grant, latch addr/we/wdata from the winner and go to ISSUE.
- ISSUE, cycle T+1:
  - mem_en=1; mem_addr/mem_we/mem_wdata come from the latched values; mem_we=1 only for a D store.
  - A store goes to DONE. A load or fetch loads counter=MEM_LATENCY-1 and goes to WAIT.
- WAIT:
  - mem_en=0; the counter decrements each cycle.
  - When the counter reaches 0 (cycle T+1+MEM_LATENCY, where mem_rdata is valid), capture mem_rdata into inst_rdata or data_rdata per grant, then go to DONE.
- DONE:
  - The granted ready pulses for one cycle, then the FSM returns to IDLE.
  - Resulting completion times: load/fetch ready at T+2+MEM_LATENCY; store ready at T+2.
- Requester rule: deassert req, or present a new one, in the cycle after ready. IDLE samples again at DONE+1, so back-to-back accesses cost no bubble beyond IDLE.
- rdata registers hold their value after ready falls; they update only on a capture.
- Simultaneous inst_req and data_req in IDLE: D served first, I served next. I waits a total of one extra access.
- A req arriving while busy is not dropped: the requester holds it and it is sampled at the next IDLE.
- Reset mid-operation:
  - State returns to IDLE on the next edge; mem_en falls.
  - No ready is produced for the aborted access, and an in-flight read result is discarded.
- Addresses pass through unchanged; misalignment is not checked here.
- The counter is CNT_W bits and never wraps, because MEM_LATENCY ≤ 2^CNT_W−1.

Decomposition:
- Add the FSM state encodings (MA_IDLE=2'b00, MA_ISSUE=2'b01, MA_WAIT=2'b10, MA_DONE=2'b11) and grant encodings (GNT_I, GNT_D) to defines.vh alongside the opcode defines.
- A single module is sufficient. The latency counter is inline; no sub-module.

Test Plan:
- Single fetch, MEM_LATENCY=2: inst_req=1 with inst_addr=0x00000010 at T, SRAM returns 0x3C011234 → mem_en=1 only at T+1 with mem_addr=0x10, mem_we=0; inst_ready=1 only at T+4 with inst_rdata=0x3C011234; stall_if=1 over T..T+3.
- Store: data_req=1, data_we=1, data_addr=0x00000100, data_wdata=0xDEADBEEF at T → mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF at T+1; data_ready=1 at T+2; no capture into data_rdata.
- Contention: inst_req and data_req both rise at T, data is a load → D issued at T+1 with data_ready at T+4; I sampled at T+5, issued at T+6, inst_ready at T+9; stall_if=1 throughout T..T+8.
- Back-to-back loads: a second data_req is presented in the cycle after data_ready → its mem_en comes exactly 2 cycles after that ready; data_rdata shows each word in its own ready cycle.
- Reset mid-WAIT: rst=1 in T+2 of a fetch → IDLE at T+3; no inst_ready pulse; mem_en stays 0; every output is 0.
- Latency sweep: MEM_LATENCY=1 and MEM_LATENCY=15 → fetch ready at T+3 and T+17 respectively; the counter never underflows.
